// File: rtl/ps2_host_pkg.sv
// ---------------------------------------------------------------------------
// ps2_host_pkg
// Shared definitions for the PS/2 host paths (transmit now, receive later).
// Holds the controller state encoding, the default line timing in 50 MHz
// clock cycles, and the odd-parity helper used on the wire.
// ---------------------------------------------------------------------------
package ps2_host_pkg;

  // 100 us clock-line inhibit and 15 ms whole-transfer timeout at 50 MHz
  localparam int PS2_INHIBIT_CYCLES = 5000;
  localparam int PS2_TIMEOUT_CYCLES = 750000;

  // Controller states, kept as plain constants so older tools can share them
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_RTS       = 3'd2;
  localparam logic [2:0] ST_DATA      = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  // PS/2 frames carry odd parity: the parity bit makes the count of ones odd
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_sync_edge.sv
// ---------------------------------------------------------------------------
// ps2_sync_edge
// Two-flop synchronizer for an asynchronous PS/2 pad level, plus a
// falling-edge detector on the synchronized value.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset (flops reset to the idle level 1)
//   din   - raw pad level
//   sync  - synchronized level
//   fall  - one-cycle pulse when sync goes from 1 to 0
// ---------------------------------------------------------------------------
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic fall
);

  logic meta;
  logic prev;

  // Reset to 1 so that leaving reset never looks like a falling edge on an
  // idle (pulled-up) line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign fall = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device command transmitter. Inhibits the clock line, issues a
// request-to-send, shifts out 8 data bits LSB first, odd parity and stop on
// the device's falling clock edges, then samples the device acknowledge.
// Ports:
//   wb_clk_i                   - 50 MHz system clock
//   wb_rst_n_i                 - asynchronous active-low reset
//   tx_data_i / tx_valid_i     - command byte and request
//   tx_ready_o                 - high only when idle (request accepted)
//   ps2_clk_i / ps2_dat_i      - raw pad levels
//   ps2_clk_oe_o/ps2_dat_oe_o  - 1 pulls the line low, 0 releases it
//   busy_o                     - high whenever not idle
//   done_o / err_o             - one-cycle ack / failure pulses
// ---------------------------------------------------------------------------
module ps2_host_tx
  import ps2_host_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_n_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_dat_oe_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic [3:0]    edge_cnt;
  logic [7:0]    data_q;
  logic          parity_q;
  logic          dat_oe_q;
  logic          sync_clk;
  logic          clk_fall;
  logic          dat_meta;
  logic          sync_dat;
  logic          in_xfer;

  ps2_sync_edge u_clk_sync (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .din   (ps2_clk_i),
    .sync  (sync_clk),
    .fall  (clk_fall)
  );

  // The data line only needs its level, so it gets a bare two-flop
  // synchronizer; reset value 1 matches the released line.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      dat_meta <= 1'b1;
      sync_dat <= 1'b1;
    end else begin
      dat_meta <= ps2_dat_i;
      sync_dat <= dat_meta;
    end
  end

  // The timeout only runs while the device owns the clock.
  assign in_xfer = (state == ST_RTS) || (state == ST_DATA) || (state == ST_ACK);

  // Main controller. Timeout is checked first so that it wins over a falling
  // edge arriving in the same cycle. In DATA the edge counter holds the number
  // of edges already seen, so the bit driven on the next edge is
  // data_q[edge_cnt] for edges 2..8.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state    <= ST_IDLE;
      inh_cnt  <= '0;
      to_cnt   <= '0;
      edge_cnt <= '0;
      data_q   <= '0;
      parity_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      if (in_xfer && (to_cnt == TO_LAST)) begin
        state    <= ST_IDLE;
        err_o    <= 1'b1;
        dat_oe_q <= 1'b0;
      end else begin
        if (in_xfer) begin
          to_cnt <= to_cnt + TW'(1);
        end
        case (state)
          ST_IDLE: begin
            if (tx_valid_i) begin
              data_q   <= tx_data_i;
              parity_q <= odd_parity(tx_data_i);
              inh_cnt  <= '0;
              edge_cnt <= '0;
              state    <= ST_INHIBIT;
            end
          end
          ST_INHIBIT: begin
            if (inh_cnt == INH_LAST) begin
              to_cnt <= '0;
              state  <= ST_RTS;
            end else begin
              inh_cnt <= inh_cnt + IW'(1);
            end
          end
          ST_RTS: begin
            if (clk_fall) begin
              dat_oe_q <= ~data_q[0];
              edge_cnt <= 4'd1;
              state    <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (clk_fall) begin
              edge_cnt <= edge_cnt + 4'd1;
              if (edge_cnt == 4'd9) begin
                dat_oe_q <= 1'b0;
                state    <= ST_ACK;
              end else if (edge_cnt == 4'd8) begin
                dat_oe_q <= ~parity_q;
              end else begin
                dat_oe_q <= ~data_q[edge_cnt[2:0]];
              end
            end
          end
          ST_ACK: begin
            if (clk_fall) begin
              edge_cnt <= 4'd11;
              if (sync_dat) begin
                err_o <= 1'b1;
              end else begin
                done_o <= 1'b1;
              end
              state <= ST_WAIT_IDLE;
            end
          end
          ST_WAIT_IDLE: begin
            if (sync_clk && sync_dat) begin
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Line drivers decode straight from state so that an asynchronous reset
  // releases both lines without waiting for a clock edge. The last inhibit
  // cycle also pulls data low, ahead of releasing the clock.
  always_comb begin
    ps2_clk_oe_o = 1'b0;
    ps2_dat_oe_o = 1'b0;
    case (state)
      ST_INHIBIT: begin
        ps2_clk_oe_o = 1'b1;
        ps2_dat_oe_o = (inh_cnt == INH_LAST);
      end
      ST_RTS:  ps2_dat_oe_o = 1'b1;
      ST_DATA: ps2_dat_oe_o = dat_oe_q;
      default: ;
    endcase
  end

  assign tx_ready_o = (state == ST_IDLE);
  assign busy_o     = (state != ST_IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Directed bench for ps2_host_tx with a simple PS/2 device model that clocks
// the bus and samples the data line on each rising clock edge. The device
// clock runs faster than a real device (80 system cycles per bit) and the
// transfer timeout is shortened so the run stays short; the inhibit time
// uses its normal 5000-cycle value.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int INHIBIT = 5000;
  localparam int TIMEOUT = 3000;
  localparam int HALF    = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       clk_oe;
  logic       dat_oe;
  logic       busy;
  logic       done;
  logic       err;
  logic       dev_clk_low;
  logic       dev_dat_low;
  logic       clk_line;
  logic       dat_line;

  int checks;
  int errors;
  int done_cnt     = 0;
  int err_cnt      = 0;
  int clk_low_cnt  = 0;
  int inh_only_cnt = 0;

  always #10 clk = ~clk;

  // Open-collector bus: either side can pull a line low
  assign clk_line = ~(clk_oe | dev_clk_low);
  assign dat_line = ~(dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INHIBIT),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_n_i   (rst_n),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .ps2_clk_i    (clk_line),
    .ps2_dat_i    (dat_line),
    .ps2_clk_oe_o (clk_oe),
    .ps2_dat_oe_o (dat_oe),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  // Running tallies of result pulses and of cycles the host holds the clock
  // low, read as before/after differences by the main sequence.
  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (clk_oe) clk_low_cnt <= clk_low_cnt + 1;
    if (clk_oe && !dat_oe) inh_only_cnt <= inh_only_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  // Present one request for a single cycle
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device model: wait for request-to-send, then give n_edges clock pulses,
  // sampling data on each rising edge; optionally pull data low for the ack.
  task automatic deviceTransfer(input int n_edges, input bit ack, output logic [9:0] bits);
    bit seen;
    bits = '0;
    seen = 1'b0;
    for (int i = 0; i < 12000 && !seen; i++) begin
      @(negedge clk);
      if (clk_line && !dat_line) seen = 1'b1;
    end
    checkOutput("rts_seen", 32'(seen), 32'd1);
    if (!seen) return;
    repeat (HALF) @(negedge clk);
    for (int k = 1; k <= n_edges; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k <= 10) bits[k-1] = dat_line;
      if (k == 10 && ack) dev_dat_low = 1'b1;
      repeat (HALF) @(negedge clk);
    end
  endtask

  // Wait (bounded) for the host to return to idle, then check the bus
  task automatic waitIdle(input string tag);
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    checkOutput({tag, "_lines"}, 32'({clk_line, dat_line}), 32'd3);
  endtask

  // Full transfer acknowledged by the device
  task automatic runAckTransfer(input logic [7:0] b, input logic exp_par, input string tag);
    logic [9:0] bits;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    applyStimulus(b);
    deviceTransfer(11, 1'b1, bits);
    checkOutput({tag, "_data"}, 32'(bits[7:0]), 32'(b));
    checkOutput({tag, "_parity"}, 32'(bits[8]), 32'(exp_par));
    checkOutput({tag, "_stop"}, 32'(bits[9]), 32'd1);
    checkOutput({tag, "_busy_hold"}, 32'(busy), 32'd1);
    dev_dat_low = 1'b0;
    waitIdle(tag);
    checkOutput({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
    checkOutput({tag, "_err"}, 32'(err_cnt - e0), 32'd0);
  endtask

  initial begin
    logic [9:0] bits;
    int d0, e0, c0, i0, n;
    bit seen;

    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    tx_data     = 8'h00;
    tx_valid    = 1'b0;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(tx_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_clk_oe", 32'(clk_oe), 32'd0);
    checkOutput("rst_dat_oe", 32'(dat_oe), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Acknowledged transfers: 0xED, 0x01 (parity 0), 0xFF (parity 1)
    runAckTransfer(8'hED, 1'b1, "ed");
    runAckTransfer(8'h01, 1'b0, "x01");
    runAckTransfer(8'hFF, 1'b1, "xff");

    // Missing acknowledge
    d0 = done_cnt;
    e0 = err_cnt;
    applyStimulus(8'hF4);
    deviceTransfer(11, 1'b0, bits);
    checkOutput("f4_data", 32'(bits[7:0]), 32'h0000_00F4);
    waitIdle("f4");
    checkOutput("f4_err", 32'(err_cnt - e0), 32'd1);
    checkOutput("f4_done", 32'(done_cnt - d0), 32'd0);

    // Device never clocks: timeout counted from the first RTS cycle
    d0 = done_cnt;
    e0 = err_cnt;
    applyStimulus(8'hAA);
    seen = 1'b0;
    for (int i = 0; i < 12000 && !seen; i++) begin
      @(negedge clk);
      if (!clk_oe && dat_oe) seen = 1'b1;
    end
    checkOutput("to_rts_seen", 32'(seen), 32'd1);
    n = 0;
    for (int i = 0; i < TIMEOUT + 50 && !err; i++) begin
      @(negedge clk);
      n++;
    end
    checkOutput("to_cycles", 32'(n), 32'(TIMEOUT));
    checkOutput("to_clk_oe", 32'(clk_oe), 32'd0);
    checkOutput("to_dat_oe", 32'(dat_oe), 32'd0);
    checkOutput("to_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("to_err", 32'(err_cnt - e0), 32'd1);
    checkOutput("to_done", 32'(done_cnt - d0), 32'd0);

    // Inhibit duration, and a request during inhibit is dropped
    d0 = done_cnt;
    c0 = clk_low_cnt;
    i0 = inh_only_cnt;
    applyStimulus(8'hAA);
    repeat (100) @(negedge clk);
    checkOutput("inh_ready", 32'(tx_ready), 32'd0);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    deviceTransfer(11, 1'b1, bits);
    checkOutput("inh_data", 32'(bits[7:0]), 32'h0000_00AA);
    checkOutput("inh_parity", 32'(bits[8]), 32'd1);
    checkOutput("inh_clk_low", 32'(clk_low_cnt - c0), 32'(INHIBIT + 1));
    checkOutput("inh_only", 32'(inh_only_cnt - i0), 32'(INHIBIT));
    dev_dat_low = 1'b0;
    waitIdle("inh");
    checkOutput("inh_done", 32'(done_cnt - d0), 32'd1);

    // Reset after the fourth data edge, then a clean transfer
    d0 = done_cnt;
    e0 = err_cnt;
    applyStimulus(8'hED);
    deviceTransfer(4, 1'b0, bits);
    checkOutput("mid_busy_before", 32'(busy), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("mid_clk_oe", 32'(clk_oe), 32'd0);
    checkOutput("mid_dat_oe", 32'(dat_oe), 32'd0);
    checkOutput("mid_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("mid_ready", 32'(tx_ready), 32'd1);
    checkOutput("mid_no_done", 32'(done_cnt - d0), 32'd0);
    checkOutput("mid_no_err", 32'(err_cnt - e0), 32'd0);
    runAckTransfer(8'hED, 1'b1, "post");

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
